// File: rtl/key_expansion.sv
// key_expansion: AES key schedule, one word per enabled cycle into a flat round-key register
module key_expansion #(
  parameter int nk = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [32*nk-1:0]        key,
  output logic [128*(nk+7)-1:0]   outKeys
);
  localparam int nw = 4 * (nk + 7);
  localparam int ow = 32 * nw;
  localparam logic [2047:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return sbox_tab[2047 - 8*int'(b) -: 8];
  endfunction
  logic [5:0]  i;
  logic [2:0]  m;
  logic [7:0]  rc;
  logic [31:0] prev, back, sub_in, sub_out, temp, next_w;
  always_comb begin
    prev   = outKeys[ow - 1 - 32*(int'(i) - 1) -: 32];
    back   = outKeys[ow - 1 - 32*(int'(i) - nk) -: 32];
    sub_in = (m == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    temp   = (m == 3'd0) ? sub_out ^ {rc, 24'h0} :
             (nk == 8 && m == 3'd4) ? sub_out : prev;
    next_w = back ^ temp;
  end
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
  end
  // m tracks i mod nk; rc holds Rcon[i/nk] and doubles in GF(2^8) after each use
  always_ff @(posedge clk) begin
    if (reset) begin
      outKeys <= {key, {(ow - 32*nk){1'b0}}};
      i       <= 6'(nk);
      m       <= 3'd0;
      rc      <= 8'h01;
    end else if (enable && i < 6'(nw)) begin
      outKeys[ow - 1 - 32*int'(i) -: 32] <= next_w;
      i  <= i + 6'd1;
      m  <= (m == 3'(nk - 1)) ? 3'd0 : m + 3'd1;
      rc <= (m == 3'd0) ? ({rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00)) : rc;
    end
  end
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: directed AES-128/192/256 schedule vectors checked through a scoreboard queue
module tb_key_expansion;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst4 = 0, en4 = 0, rst6 = 0, en6 = 0, rst8 = 0, en8 = 0;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [1407:0] out4;
  logic [1663:0] out6;
  logic [1919:0] out8;

  key_expansion #(.nk(4)) d4 (.clk(clk), .reset(rst4), .enable(en4), .key(key4), .outKeys(out4));
  key_expansion #(.nk(6)) d6 (.clk(clk), .reset(rst6), .enable(en6), .key(key6), .outKeys(out6));
  key_expansion #(.nk(8)) d8 (.clk(clk), .reset(rst8), .enable(en8), .key(key8), .outKeys(out8));

  localparam logic [127:0] k4c = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] k6c = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] k8c = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic [127:0] rk4 [0:10] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};

  typedef struct {
    int          id;
    int          k;
    logic [31:0] exp;
    string       name;
  } ent_t;
  ent_t sb[$];
  event snap;
  int total = 0, bad = 0;

  function automatic logic [31:0] got(int id, int k);
    if (id == 4) return out4[1407 - 32*k -: 32];
    if (id == 6) return out6[1663 - 32*k -: 32];
    return out8[1919 - 32*k -: 32];
  endfunction

  initial forever begin
    @(snap);
    while (sb.size() != 0) begin
      ent_t e;
      logic [31:0] g;
      e = sb.pop_front();
      g = got(e.id, e.k);
      total++;
      if (g !== e.exp) begin
        bad++;
        $display("FAIL %s nk=%0d w%0d got=%h want=%h", e.name, e.id, e.k, g, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_w(input int id, input int k, input logic [31:0] v, input string name);
    ent_t e;
    e.id = id; e.k = k; e.exp = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic push_rk(input int id, input int k0, input logic [127:0] v, input string name);
    for (int j = 0; j < 4; j++) push_w(id, k0 + j, v[127 - 32*j -: 32], name);
  endtask

  // Words below nvalid hold the known schedule, the rest must read 0
  task automatic check4(input int nvalid, input string name);
    for (int k = 0; k < 44; k++) begin
      logic [127:0] r;
      r = rk4[k/4];
      push_w(4, k, (k < nvalid) ? r[127 - 32*(k%4) -: 32] : 32'h0, name);
    end
    -> snap;
  endtask

  task automatic reset4();
    rst4 = 1;
    tick(1);
    rst4 = 0;
  endtask

  task automatic run4(input int n);
    en4 = 1;
    tick(n);
    en4 = 0;
  endtask

  initial begin
    key4 = k4c; key6 = k6c; key8 = k8c;
    tick(2);
    reset4();
    check4(4, "reset_state");
    tick(1);
    run4(40);
    check4(44, "full128");
    tick(1);
    reset4();
    run4(10);
    tick(20);
    check4(14, "hold_frozen");
    tick(1);
    run4(30);
    check4(44, "hold_resume");
    tick(1);
    reset4();
    check4(4, "reset_after_done");
    tick(50);
    check4(4, "idle_after_reset");
    tick(1);
    run4(40);
    check4(44, "rerun");
    tick(1);
    reset4();
    run4(17);
    en4 = 1;
    rst4 = 1;
    tick(1);
    rst4 = 0;
    en4 = 0;
    check4(4, "midrun_reset");
    tick(1);
    run4(40);
    check4(44, "after_midrun");
    tick(1);
    rst4 = 1;
    en4 = 1;
    tick(3);
    rst4 = 0;
    en4 = 0;
    check4(4, "reset_priority");
    tick(1);
    run4(1);
    check4(5, "first_word");
    tick(1);
    key4 = 128'hdeadbeefcafef00d0123456789abcdef;
    tick(2);
    run4(39);
    check4(44, "key_not_resampled");
    tick(1);
    key4 = k4c;
    rst6 = 1;
    tick(1);
    rst6 = 0;
    for (int k = 0; k < 6; k++) push_w(6, k, k6c[191 - 32*k -: 32], "reset192");
    push_w(6, 6, 32'h0, "reset192");
    push_w(6, 51, 32'h0, "reset192");
    -> snap;
    tick(1);
    en6 = 1;
    tick(46);
    en6 = 0;
    push_w(6, 6, 32'h5846f2f9, "w6_192");
    push_rk(6, 48, 128'ha4970a331a78dc09c418c271e3a41d5d, "rk12_192");
    -> snap;
    tick(1);
    rst8 = 1;
    tick(1);
    rst8 = 0;
    for (int k = 0; k < 8; k++) push_w(8, k, k8c[255 - 32*k -: 32], "reset256");
    push_w(8, 8, 32'h0, "reset256");
    -> snap;
    tick(1);
    en8 = 1;
    tick(52);
    en8 = 0;
    push_rk(8, 8, 128'ha573c29fa176c498a97fce93a572c09c, "rk2_256");
    push_rk(8, 56, 128'h24fc79ccbf0979e9371ac23c6d68de36, "rk14_256");
    -> snap;
    tick(2);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
